// File: rtl/frame_receiver.sv
// Receive end of a framed stream: checks SOF/EOF structure against FRAME_LEN, re-hunts
// for SOF after loss of lock, and forwards payload through a 2-entry skid buffer.
module frame_receiver #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 1024,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [DW-1:0] tdata_s,
    input  logic          tvalid_s,
    output logic          tready_s,
    input  logic          tlast_s,
    input  logic          tuser_s,
    output logic [DW-1:0] tdata_m,
    output logic          tvalid_m,
    input  logic          tready_m,
    output logic          sof_m,
    output logic          eof_m,
    output logic          locked,
    output logic          frame_err,
    output logic [CW-1:0] err_cnt,
    input  logic          err_clr
);
    localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    // Handshake: a beat moves on either side only in a cycle where valid and ready are
    // both high at the rising edge; ready never depends on valid on the same side.
    state_t        state, state_nxt;
    logic [IW-1:0] cnt, cnt_nxt;
    logic          fwd, fwd_sof, fwd_eof, err_nxt;
    logic          accept, push, pop;
    logic          ready_q;
    logic [1:0]    count, count_nxt;
    logic          wr_ptr, rd_ptr;
    logic [DW+1:0] mem [2];

    assign tready_s = ready_q & ce;
    assign accept   = tvalid_s & tready_s & ce;
    assign push     = accept & fwd;
    assign pop      = tvalid_m & tready_m;
    assign tvalid_m = (count != 2'd0);
    assign {sof_m, eof_m, tdata_m} = mem[rd_ptr];
    assign locked   = (state == LOCK);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fwd       = 1'b0;
        fwd_sof   = 1'b0;
        fwd_eof   = 1'b0;
        err_nxt   = 1'b0;
        if (accept) begin
            case (state)
                HUNT: begin
                    if (tuser_s) begin
                        fwd       = 1'b1;
                        fwd_sof   = 1'b1;
                        cnt_nxt   = IW'(1);
                        state_nxt = LOCK;
                    end
                end
                default: begin
                    if (tuser_s && cnt != '0) begin
                        // short frame: resynchronise on the new SOF without losing lock
                        err_nxt = 1'b1;
                        fwd     = 1'b1;
                        fwd_sof = 1'b1;
                        cnt_nxt = IW'(1);
                    end else if (cnt == '0 && !tuser_s) begin
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                    end else if (tlast_s && cnt != LAST) begin
                        err_nxt   = 1'b1;
                        fwd       = 1'b1;
                        fwd_sof   = (cnt == '0);
                        cnt_nxt   = '0;
                        state_nxt = HUNT;
                    end else if (cnt == LAST && !tlast_s) begin
                        err_nxt   = 1'b1;
                        fwd       = 1'b1;
                        fwd_eof   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = HUNT;
                    end else begin
                        fwd     = 1'b1;
                        fwd_sof = (cnt == '0);
                        fwd_eof = (cnt == LAST);
                        cnt_nxt = (cnt == LAST) ? '0 : cnt + IW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            cnt       <= '0;
            frame_err <= 1'b0;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            ready_q   <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            frame_err <= err_nxt;
            count     <= count_nxt;
            // registered ready: at most one push per cycle, so ready when <2 leaves room
            ready_q   <= (count_nxt != 2'd2);
            if (push) begin
                mem[wr_ptr] <= {fwd_sof, fwd_eof, tdata_s};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      err_cnt <= '0;
        else if (err_clr)                  err_cnt <= '0;
        else if (frame_err && err_cnt != '1) err_cnt <= err_cnt + CW'(1);
    end
endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver with FRAME_LEN=8: drives frames, scoreboards the
// output stream, and checks error counting, lock state and reset behaviour.
module tb_frame_receiver;
    localparam int DW = 16;
    localparam int FL = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce = 1'b1;
    logic [DW-1:0] tdata_s = '0;
    logic          tvalid_s = 1'b0;
    logic          tready_s;
    logic          tlast_s = 1'b0;
    logic          tuser_s = 1'b0;
    logic [DW-1:0] tdata_m;
    logic          tvalid_m;
    logic          tready_m = 1'b1;
    logic          sof_m, eof_m, locked, frame_err;
    logic [CW-1:0] err_cnt;
    logic          err_clr = 1'b0;

    frame_receiver #(.DW(DW), .FRAME_LEN(FL), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
        .tlast_s(tlast_s), .tuser_s(tuser_s),
        .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
        .sof_m(sof_m), .eof_m(eof_m), .locked(locked),
        .frame_err(frame_err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
    logic [DW+1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor: decides tready_m each negedge and scoreboards transferred beats.
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_beat = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tvalid_m), 32'd1);
                chk("hold_beat", 32'({sof_m, eof_m, tdata_m}), 32'(prev_beat));
            end
            case (rdy_mode)
                0:       tready_m = 1'b1;
                1:       tready_m = 1'($urandom_range(0, 1));
                default: tready_m = 1'b0;
            endcase
            if (tvalid_m && tready_m) begin
                if (exp_q.size() == 0) chk("extra_beat", 32'(tdata_m), 32'hffff_ffff);
                else chk("out_beat", 32'({sof_m, eof_m, tdata_m}), 32'(exp_q.pop_front()));
            end
            prev_stall = tvalid_m && !tready_m;
            prev_beat  = {sof_m, eof_m, tdata_m};
        end
    end

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [DW-1:0] d, input logic u, input logic l,
                        input logic f, input logic s, input logic e);
        int n = 0;
        tdata_s  = d;
        tuser_s  = u;
        tlast_s  = l;
        tvalid_s = 1'b1;
        while (!tready_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
        if (f) exp_q.push_back({s, e, d});
        @(negedge clk);
        tvalid_s = 1'b0;
        tuser_s  = 1'b0;
        tlast_s  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++)
            send(base + DW'(i), i == 0, i == FL - 1, 1'b1, i == 0, i == FL - 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("drain_idle", 32'(tvalid_m), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tvalid_m", 32'(tvalid_m), 32'd0);
        chk("rst_tdata_m", 32'(tdata_m), 32'd0);
        chk("rst_sof_eof", 32'({sof_m, eof_m}), 32'd0);
        chk("rst_tready_s", 32'(tready_s), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // three clean frames, data 0..23
        send(16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("lock_first_beat", 32'(locked), 32'd1);
        for (int i = 1; i < 3 * FL; i++)
            send(DW'(i), (i % FL) == 0, (i % FL) == FL - 1, 1'b1, (i % FL) == 0, (i % FL) == FL - 1);
        drain();
        chk("clean_err_cnt", 32'(err_cnt), 32'd0);
        chk("clean_locked", 32'(locked), 32'd1);

        ce = 1'b0;
        @(negedge clk);
        chk("ce_low_tready", 32'(tready_s), 32'd0);
        ce = 1'b1;
        @(negedge clk);

        // SOF repeated at beat 3: new frame starts there, lock kept
        for (int i = 0; i < 3; i++) send(16'd200 + DW'(i), i == 0, 1'b0, 1'b1, i == 0, 1'b0);
        send(16'd203, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < FL; i++) send(16'd203 + DW'(i), 1'b0, i == FL - 1, 1'b1, 1'b0, i == FL - 1);
        drain();
        chk("short_err_cnt", 32'(err_cnt), 32'd1);
        chk("short_locked", 32'(locked), 32'd1);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // early EOF at beat 5, then a non-SOF beat is dropped while hunting
        send(16'd300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send(16'd300 + DW'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'd305, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("early_unlock", 32'(locked), 32'd0);
        send(16'd306, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        chk("early_err_cnt", 32'(err_cnt), 32'd1);
        chk("early_locked", 32'(locked), 32'd0);

        // hunting: five beats without SOF are dropped silently, then a clean frame
        for (int i = 0; i < 5; i++) send(16'd400 + DW'(i), 1'b0, i == 4, 1'b0, 1'b0, 1'b0);
        chk("hunt_locked", 32'(locked), 32'd0);
        send_frame(16'd410);
        drain();
        chk("hunt_err_cnt", 32'(err_cnt), 32'd1);
        chk("hunt_relocked", 32'(locked), 32'd1);

        // random backpressure over 10 frames
        rdy_mode = 1;
        for (int f = 0; f < 10; f++) send_frame(16'h1000 + DW'(f * 16));
        drain();
        rdy_mode = 0;
        chk("bp_err_cnt", 32'(err_cnt), 32'd1);
        chk("bp_locked", 32'(locked), 32'd1);

        // missing SOF with err_clr in the same cycle as frame_err
        send(16'd520, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("miss_frame_err", 32'(frame_err), 32'd1);
        chk("miss_unlock", 32'(locked), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_pulse_width", 32'(frame_err), 32'd0);
        chk("clr_priority", 32'(err_cnt), 32'd0);

        // build a non-zero count, then reset mid-frame with a beat buffered
        send_frame(16'd600);
        send(16'd620, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(16'd700 + DW'(i), i == 0, 1'b0, 1'b1, i == 0, 1'b0);
        drain();
        chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
        chk("pre_rst_locked", 32'(locked), 32'd1);
        rdy_mode = 2;
        send(16'd704, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("buffered_valid", 32'(tvalid_m), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_tvalid_m", 32'(tvalid_m), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        send(16'd705, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_locked", 32'(locked), 32'd0);
        send_frame(16'd800);
        drain();
        chk("relock", 32'(locked), 32'd1);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "bench timeout");
    end
endmodule
